// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding and strobe priority decode.
package pc_pkg;

  typedef enum logic [2:0] {OP_INC, OP_RET, OP_CALL, OP_BR, OP_JMP} pc_op_e;

  localparam int DEFAULT_W     = 4;
  localparam int DEFAULT_DEPTH = 4;
  localparam int SPW           = $clog2(DEFAULT_DEPTH + 1);

  // Several strobes may be high together; the highest-priority one is the only one acted on.
  function automatic pc_op_e decode_op(input logic jmp, input logic br,
                                       input logic call, input logic ret);
    pc_op_e op;
    op = OP_INC;
    if (jmp)       op = OP_JMP;
    else if (br)   op = OP_BR;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    return op;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control-unit side bundle of the PC sequencer: op strobes in, fetch address and stack status out.
interface pc_seq_if #(parameter int W = 4, parameter int DEPTH = 4);

  localparam int SPW = $clog2(DEPTH + 1);

  logic           enable;
  logic           jmp;
  logic           br;
  logic           call;
  logic           ret;
  logic [W-1:0]   target;
  logic [W-1:0]   offset;
  logic [W-1:0]   count;
  logic [SPW-1:0] sp;
  logic           stk_full;
  logic           stk_empty;
  logic           err_ovf;
  logic           err_unf;

  modport master (
    output enable, jmp, br, call, ret, target, offset,
    input  count, sp, stk_full, stk_empty, err_ovf, err_unf
  );

  modport slave (
    input  enable, jmp, br, call, ret, target, offset,
    output count, sp, stk_full, stk_empty, err_ovf, err_unf
  );

endinterface

// File: rtl/pc_stack.sv
// Return-address LIFO, DEPTH entries of W bits; push is ignored when full, pop when empty.
module pc_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top_data,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [W-1:0] mem [DEPTH];

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);

  // Entry i is written when sp == i, so the top of stack always sits at index sp-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (sp == SPW'(i)) mem[i] <= push_data;
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SPW'(i + 1)) top_data = mem[i];
  end

endmodule

// File: rtl/pc_seq.sv
// Program counter with increment, absolute jump, signed relative branch and CALL/RET stack.
module pc_seq
  import pc_pkg::*;
#(
  parameter int           W      = 4,
  parameter int           DEPTH  = 4,
  parameter logic [W-1:0] RST_PC = '0
) (
  input logic      clk,
  input logic      rst,
  pc_seq_if.slave  bus
);

  pc_op_e       op;
  logic [W-1:0] count_q;
  logic [W-1:0] count_inc;
  logic [W-1:0] top_data;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         ovf_q;
  logic         unf_q;

  assign op        = decode_op(bus.jmp, bus.br, bus.call, bus.ret);
  assign count_inc = count_q + W'(1);
  assign push      = bus.enable && (op == OP_CALL) && !full;
  assign pop       = bus.enable && (op == OP_RET) && !empty;

  pc_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (count_inc),
    .top_data  (top_data),
    .sp        (bus.sp),
    .full      (full),
    .empty     (empty)
  );

  // A call on a full stack or a ret on an empty one degrades to a plain increment and sets its sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_PC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.enable) begin
      case (op)
        OP_JMP:  count_q <= bus.target;
        OP_BR:   count_q <= count_q + bus.offset;
        OP_CALL: begin
          if (full) begin
            ovf_q   <= 1'b1;
            count_q <= count_inc;
          end else begin
            count_q <= bus.target;
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_q   <= 1'b1;
            count_q <= count_inc;
          end else begin
            count_q <= top_data;
          end
        end
        default: count_q <= count_inc;
      endcase
    end
  end

  assign bus.count     = count_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_unf   = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Randomised and directed bench for pc_seq against a queue-based reference model.
module tb_pc_seq;

  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int MOD   = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_seq_if #(.W(W), .DEPTH(DEPTH)) bus();

  pc_seq #(.W(W), .DEPTH(DEPTH), .RST_PC(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_count;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  task automatic check_output(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".count"}, int'(bus.count), m_count);
    check_output({tag, ".sp"}, int'(bus.sp), m_stk.size());
    check_output({tag, ".full"}, int'(bus.stk_full), int'(m_stk.size() == DEPTH));
    check_output({tag, ".empty"}, int'(bus.stk_empty), int'(m_stk.size() == 0));
    check_output({tag, ".ovf"}, int'(bus.err_ovf), int'(m_ovf));
    check_output({tag, ".unf"}, int'(bus.err_unf), int'(m_unf));
  endtask

  task automatic model_reset();
    m_count = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Reference behaviour straight from the op rules, with the return stack as a queue.
  task automatic model_step(input bit en, input bit j, input bit b, input bit c, input bit r,
                            input int t, input int o);
    int disp;
    if (!en) return;
    if (j) begin
      m_count = t;
    end else if (b) begin
      disp    = (o >= MOD / 2) ? o - MOD : o;
      m_count = (m_count + disp + MOD) % MOD;
    end else if (c) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back((m_count + 1) % MOD);
        m_count = t;
      end else begin
        m_ovf   = 1'b1;
        m_count = (m_count + 1) % MOD;
      end
    end else if (r) begin
      if (m_stk.size() > 0) begin
        m_count = m_stk.pop_back();
      end else begin
        m_unf   = 1'b1;
        m_count = (m_count + 1) % MOD;
      end
    end else begin
      m_count = (m_count + 1) % MOD;
    end
  endtask

  task automatic drive(input bit en, input bit j, input bit b, input bit c, input bit r,
                       input int t, input int o);
    bus.enable = en;
    bus.jmp    = j;
    bus.br     = b;
    bus.call   = c;
    bus.ret    = r;
    bus.target = W'(t);
    bus.offset = W'(o);
  endtask

  task automatic apply_stimulus(input bit en, input bit j, input bit b, input bit c, input bit r,
                                input int t, input int o, input string tag);
    @(negedge clk);
    drive(en, j, b, c, r, t, o);
    @(posedge clk);
    model_step(en, j, b, c, r, t, o);
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    model_reset();
    do_reset();

    for (int i = 0; i < 17; i++) apply_stimulus(1, 0, 0, 0, 0, 0, 0, "inc");
    check_output("wrap_count", int'(bus.count), 1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0, 9, 0, "hold");
    check_output("hold_count", int'(bus.count), 1);

    apply_stimulus(1, 1, 0, 0, 0, 5, 0, "jmp5");
    apply_stimulus(1, 1, 0, 0, 0, 12, 0, "jmp12");
    check_output("jmp_count", int'(bus.count), 12);
    apply_stimulus(1, 0, 1, 0, 0, 0, 4'hE, "br_m2");
    check_output("br_m2_count", int'(bus.count), 10);
    apply_stimulus(1, 1, 0, 0, 0, 1, 0, "jmp1");
    apply_stimulus(1, 0, 1, 0, 0, 0, 4'hD, "br_m3");
    check_output("br_wrap_count", int'(bus.count), 14);

    apply_stimulus(1, 1, 0, 0, 0, 3, 0, "jmp3");
    apply_stimulus(1, 0, 0, 1, 0, 8, 0, "call8");
    apply_stimulus(1, 0, 0, 1, 0, 2, 0, "call2");
    check_output("full_flag", int'(bus.stk_full), 1);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, "ret1");
    check_output("ret1_count", int'(bus.count), 9);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, "ret2");
    check_output("ret2_count", int'(bus.count), 4);

    apply_stimulus(1, 0, 0, 1, 0, 8, 0, "ovf_call8");
    apply_stimulus(1, 0, 0, 1, 0, 2, 0, "ovf_call2");
    apply_stimulus(1, 0, 0, 1, 0, 7, 0, "ovf_call7");
    check_output("ovf_count", int'(bus.count), 3);
    check_output("ovf_flag", int'(bus.err_ovf), 1);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, "unf_ret1");
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, "unf_ret2");
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, "unf_ret3");
    check_output("unf_flag", int'(bus.err_unf), 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, "sticky");

    apply_stimulus(1, 1, 1, 1, 1, 6, 3, "all_strobes");
    check_output("prio_count", int'(bus.count), 6);
    apply_stimulus(1, 0, 0, 1, 1, 11, 0, "call_ret");
    check_output("call_wins_sp", int'(bus.sp), 1);

    // Async reset lands mid-cycle while a call is being driven, with sp=1 and count=9.
    apply_stimulus(1, 1, 0, 0, 0, 9, 0, "pre_rst");
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_held");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, "post_rst");
    check_output("post_rst_count", int'(bus.count), 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        apply_stimulus($urandom_range(0, 7) != 0,
                       $urandom_range(0, 5) == 0,
                       $urandom_range(0, 4) == 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0,
                       int'($urandom_range(0, MOD - 1)),
                       int'($urandom_range(0, MOD - 1)),
                       "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
